// File: rtl/regfile_wb_ctrl_if.sv
// Write-back bus bundle: execute-side request (A), load-unit request (B),
// scoreboard/decode inputs, and the register-file write port.
interface regfile_wb_ctrl_if;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        a_stall;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        b_ready;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard;
    logic        byp1;
    logic        byp2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
               ld_issue, ld_rd, rs1, rs2,
        output a_stall, b_ready, hazard, byp1, byp2, wb_we, wb_rd, wb_data
    );

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
               ld_issue, ld_rd, rs1, rs2,
        input  a_stall, b_ready, hazard, byp1, byp2, wb_we, wb_rd, wb_data
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Shares the register-file write port between the execute pipe (A) and the
// load unit (B), with a load scoreboard and write-in-flight bypass flags.
//
// state   | meaning
// NORMAL  | A has priority; B accepted only when A is idle
// GRANT_B | one-cycle forced grant to a starved B; A is frozen
module regfile_wb_ctrl #(
    parameter int STARVE_MAX = 4
) (
    input logic              clk,
    input logic              resetn,
    regfile_wb_ctrl_if.slave bus
);
    typedef enum logic {NORMAL = 1'b0, GRANT_B = 1'b1} state_t;

    localparam logic [3:0] CNT_LAST = 4'(STARVE_MAX - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_q, pend_d;
    logic        we_q, we_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;

    logic        a_acc;
    logic        b_acc;
    logic        b_rdy;
    logic        byp1;
    logic        byp2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
            pend_q  <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    // Counter clears whenever B is not being blocked, including inside GRANT_B.
    always_comb begin
        state_d = NORMAL;
        cnt_d   = '0;
        b_rdy   = 1'b1;
        a_acc   = 1'b0;
        unique case (state_q)
            NORMAL: begin
                b_rdy = ~bus.a_valid;
                a_acc = bus.a_valid;
                if (bus.b_valid && bus.a_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = GRANT_B;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            GRANT_B: begin
                b_rdy = 1'b1;
            end
        endcase
    end

    assign b_acc = bus.b_valid & b_rdy;

    // x0 requests are consumed without touching the held wb_rd/wb_data.
    always_comb begin
        we_d   = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        if (a_acc) begin
            if (bus.a_rd != 5'd0) begin
                we_d   = 1'b1;
                rd_d   = bus.a_rd;
                data_d = bus.a_data;
            end
        end else if (b_acc) begin
            if (bus.b_rd != 5'd0) begin
                we_d   = 1'b1;
                rd_d   = bus.b_rd;
                data_d = bus.b_data;
            end
        end
    end

    // Set is applied after clear so a same-index issue/return stays pending.
    always_comb begin
        pend_d = pend_q;
        if (b_acc) begin
            pend_d[bus.b_rd] = 1'b0;
        end
        if (bus.ld_issue && (bus.ld_rd != 5'd0)) begin
            pend_d[bus.ld_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    assign byp1 = we_q & (rd_q == bus.rs1) & (bus.rs1 != 5'd0);
    assign byp2 = we_q & (rd_q == bus.rs2) & (bus.rs2 != 5'd0);

    assign bus.a_stall = (state_q == GRANT_B);
    assign bus.b_ready = b_rdy;
    assign bus.byp1    = byp1;
    assign bus.byp2    = byp2;
    assign bus.hazard  = (pend_q[bus.rs1] & ~byp1) | (pend_q[bus.rs2] & ~byp2);
    assign bus.wb_we   = we_q;
    assign bus.wb_rd   = rd_q;
    assign bus.wb_data = data_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: a behavioural model checked on every
// falling edge, plus literal expectations at the key points of each scenario.
module tb_regfile_wb_ctrl;
    localparam int STARVE_MAX = 4;

    logic clk;
    logic resetn;
    int   vectors;
    int   miscompares;

    regfile_wb_ctrl_if bus();

    regfile_wb_ctrl #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a forced grant happens once B has been blocked STARVE_MAX cycles in a row.
    bit          m_grant;
    int          m_streak;
    bit          m_pend [32];
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    function automatic bit exp_b_ready();
        return m_grant ? 1'b1 : !bus.a_valid;
    endfunction

    function automatic bit exp_byp(input logic [4:0] rs);
        return m_we && (m_rd == rs) && (rs != 5'd0);
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_grant  = 1'b0;
            m_streak = 0;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_we     = 1'b0;
            m_rd     = '0;
            m_data   = '0;
        end else begin
            bit a_take;
            bit b_take;
            bit nxt_grant;
            a_take = !m_grant && bus.a_valid;
            b_take = bus.b_valid && exp_b_ready();
            if (a_take || b_take) begin
                logic [4:0]  rd;
                logic [31:0] dat;
                rd  = a_take ? bus.a_rd : bus.b_rd;
                dat = a_take ? bus.a_data : bus.b_data;
                m_we = (rd != 5'd0);
                if (rd != 5'd0) begin
                    m_rd   = rd;
                    m_data = dat;
                end
            end else begin
                m_we = 1'b0;
            end
            if (b_take) m_pend[bus.b_rd] = 1'b0;
            if (bus.ld_issue && bus.ld_rd != 5'd0) m_pend[bus.ld_rd] = 1'b1;
            nxt_grant = 1'b0;
            if (!m_grant && bus.a_valid && bus.b_valid) begin
                m_streak++;
                if (m_streak == STARVE_MAX) begin
                    nxt_grant = 1'b1;
                    m_streak  = 0;
                end
            end else begin
                m_streak = 0;
            end
            m_grant = nxt_grant;
        end
    end

    always @(negedge clk) begin
        bit b1;
        bit b2;
        b1 = exp_byp(bus.rs1);
        b2 = exp_byp(bus.rs2);
        chk("a_stall", 32'(bus.a_stall), 32'(m_grant));
        chk("b_ready", 32'(bus.b_ready), 32'(exp_b_ready()));
        chk("byp1", 32'(bus.byp1), 32'(b1));
        chk("byp2", 32'(bus.byp2), 32'(b2));
        chk("hazard", 32'(bus.hazard),
            32'((m_pend[bus.rs1] && !b1) || (m_pend[bus.rs2] && !b2)));
        chk("wb_we", 32'(bus.wb_we), 32'(m_we));
        if (m_we) begin
            chk("wb_rd", 32'(bus.wb_rd), 32'(m_rd));
            chk("wb_data", bus.wb_data, m_data);
        end
    end

    task automatic idle_inputs();
        bus.a_valid  = 1'b0;
        bus.a_rd     = '0;
        bus.a_data   = '0;
        bus.b_valid  = 1'b0;
        bus.b_rd     = '0;
        bus.b_data   = '0;
        bus.ld_issue = 1'b0;
        bus.ld_rd    = '0;
        bus.rs1      = '0;
        bus.rs2      = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        idle_inputs();
        #23 resetn = 1'b1;
        cyc();
        #1;
        chk("rst b_ready", 32'(bus.b_ready), 32'd1);
        chk("rst hazard", 32'(bus.hazard), 32'd0);
        chk("rst wb_we", 32'(bus.wb_we), 32'd0);
        chk("rst wb_data", bus.wb_data, 32'd0);
        chk("rst a_stall", 32'(bus.a_stall), 32'd0);

        // A only
        bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'hDEADBEEF;
        cyc();
        bus.a_valid = 1'b0; bus.rs1 = 5'd5;
        #1;
        chk("a wb_we", 32'(bus.wb_we), 32'd1);
        chk("a wb_rd", 32'(bus.wb_rd), 32'd5);
        chk("a wb_data", bus.wb_data, 32'hDEADBEEF);
        chk("a byp1", 32'(bus.byp1), 32'd1);
        cyc();
        bus.rs1 = 5'd0;

        // Load hazard and its clearing by B
        bus.ld_issue = 1'b1; bus.ld_rd = 5'd7;
        cyc();
        bus.ld_issue = 1'b0; bus.rs2 = 5'd7;
        #1;
        chk("ld hazard", 32'(bus.hazard), 32'd1);
        bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'h12345678;
        #1;
        chk("ld b_ready", 32'(bus.b_ready), 32'd1);
        cyc();
        bus.b_valid = 1'b0;
        #1;
        chk("ld M+1 hazard", 32'(bus.hazard), 32'd0);
        chk("ld M+1 byp2", 32'(bus.byp2), 32'd1);
        chk("ld M+1 wb_data", bus.wb_data, 32'h12345678);
        cyc();
        #1;
        chk("ld M+2 byp2", 32'(bus.byp2), 32'd0);
        chk("ld M+2 hazard", 32'(bus.hazard), 32'd0);
        bus.rs2 = 5'd0;

        // Same-cycle set and clear of x3
        bus.ld_issue = 1'b1; bus.ld_rd = 5'd3;
        bus.b_valid  = 1'b1; bus.b_rd  = 5'd3; bus.b_data = 32'h0000_0333;
        cyc();
        bus.ld_issue = 1'b0; bus.b_valid = 1'b0; bus.rs1 = 5'd3;
        cyc();
        #1;
        chk("setclr hazard", 32'(bus.hazard), 32'd1);
        bus.b_valid = 1'b1; bus.b_rd = 5'd3; bus.b_data = 32'h0000_0444;
        cyc();
        bus.b_valid = 1'b0; bus.rs1 = 5'd0;

        // Collision: B starved, then force-granted for one cycle
        bus.a_valid = 1'b1; bus.a_rd = 5'd9;  bus.a_data = 32'hA0A0A0A0;
        bus.b_valid = 1'b1; bus.b_rd = 5'd10; bus.b_data = 32'hB0B0B0B0;
        for (int i = 0; i < STARVE_MAX; i++) begin
            #1;
            chk("coll b_ready", 32'(bus.b_ready), 32'd0);
            chk("coll a_stall", 32'(bus.a_stall), 32'd0);
            cyc();
        end
        #1;
        chk("grant a_stall", 32'(bus.a_stall), 32'd1);
        chk("grant b_ready", 32'(bus.b_ready), 32'd1);
        cyc();
        bus.b_valid = 1'b0;
        #1;
        chk("grant wb_rd", 32'(bus.wb_rd), 32'd10);
        chk("grant wb_data", bus.wb_data, 32'hB0B0B0B0);
        chk("grant a_stall off", 32'(bus.a_stall), 32'd0);
        cyc();
        #1;
        chk("resume wb_rd", 32'(bus.wb_rd), 32'd9);
        chk("resume wb_data", bus.wb_data, 32'hA0A0A0A0);

        // Forced grant where B withdraws during the grant cycle
        bus.b_valid = 1'b1; bus.b_rd = 5'd11; bus.b_data = 32'hC0C0C0C0;
        for (int i = 0; i < STARVE_MAX; i++) cyc();
        bus.b_valid = 1'b0;
        #1;
        chk("withdraw a_stall", 32'(bus.a_stall), 32'd1);
        cyc();
        #1;
        chk("withdraw wb_we", 32'(bus.wb_we), 32'd0);
        cyc();
        bus.a_valid = 1'b0;

        // x0 requests
        bus.a_valid = 1'b1; bus.a_rd = 5'd0; bus.a_data = 32'hFFFFFFFF;
        bus.ld_issue = 1'b1; bus.ld_rd = 5'd0;
        cyc();
        bus.a_valid = 1'b0; bus.ld_issue = 1'b0; bus.rs1 = 5'd0;
        #1;
        chk("x0 wb_we", 32'(bus.wb_we), 32'd0);
        chk("x0 hazard", 32'(bus.hazard), 32'd0);
        chk("x0 byp1", 32'(bus.byp1), 32'd0);
        cyc();

        // Mixed traffic from a fixed pattern table
        for (int i = 0; i < 60; i++) begin
            bus.a_valid  = (i % 3) != 0;
            bus.a_rd     = 5'((i * 7) % 32);
            bus.a_data   = 32'h1000_0000 + 32'(i);
            bus.b_valid  = (i % 5) != 4;
            bus.b_rd     = 5'((i * 3 + 1) % 32);
            bus.b_data   = 32'h2000_0000 + 32'(i);
            bus.ld_issue = (i % 4) == 1;
            bus.ld_rd    = 5'((i * 11 + 2) % 32);
            bus.rs1      = 5'((i * 5) % 32);
            bus.rs2      = 5'((i * 13 + 4) % 32);
            cyc();
        end

        // Reset mid-stream with a write in flight
        bus.a_valid = 1'b1; bus.a_rd = 5'd12; bus.a_data = 32'h5555AAAA;
        bus.b_valid = 1'b0;
        bus.ld_issue = 1'b1; bus.ld_rd = 5'd12;
        cyc();
        idle_inputs();
        bus.rs1 = 5'd12;
        #1;
        chk("pre-rst wb_we", 32'(bus.wb_we), 32'd1);
        #3 resetn = 1'b0;
        #1;
        chk("mid-rst wb_we", 32'(bus.wb_we), 32'd0);
        chk("mid-rst wb_rd", 32'(bus.wb_rd), 32'd0);
        chk("mid-rst wb_data", bus.wb_data, 32'd0);
        chk("mid-rst a_stall", 32'(bus.a_stall), 32'd0);
        chk("mid-rst hazard", 32'(bus.hazard), 32'd0);
        @(negedge clk);
        #2 resetn = 1'b1;
        cyc();
        #1;
        chk("post-rst hazard", 32'(bus.hazard), 32'd0);
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
